// File: rtl/sprite_overlay_if.sv
// sprite_overlay_if: sprite ROM read bus between the overlay and its bitmap ROM.
//   rom_addr : word address, driven by the overlay (master)
//   rom_data : {key, r, g, b}, returned by the ROM (slave) one clock after the address
// AW / DW must match the overlay's $clog2(SPR_W*SPR_H) and 3*CW+1.
interface sprite_overlay_if #(
  parameter int AW = 10,
  parameter int DW = 4
);
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_overlay.sv
// sprite_overlay: draws an SPR_W x SPR_H bitmap from a synchronous ROM over the
// incoming RGB pixel stream, at a position that is only updated between frames.
// Two-cycle pipeline: stage 0 computes the window and ROM address, stage 1 blends.
//
// Ports
//   vgaclk, reset          pixel clock, synchronous active-high reset
//   pixelEN, hcount, vcount  active-video qualifier and current pixel coordinates
//   frame_start            one-cycle pulse at the start of vertical blank
//   pos_x, pos_y, pos_wr   requested position and capture strobe
//   pos_busy               a captured position is waiting for frame_start
//   mode                   00 off, 01 invert, 10 replace, 11 colour-keyed replace
//   rin, gin, bin          background colour
//   rom                    sprite ROM bus (rom_addr out, rom_data {key,r,g,b} in)
//   rout, gout, bout, hit  registered output colour and opaque-sprite flag
//
// Optional feature: define SPRITE_BLINK_EN to hide the sprite on alternate
// runs of BLINK_FRAMES frames. Without it the sprite is always visible.
module sprite_overlay #(
  parameter int SPR_W        = 30,
  parameter int SPR_H        = 30,
  parameter int CW           = 1,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 32
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic          pixelEN,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  input  logic          frame_start,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic          pos_wr,
  output logic          pos_busy,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] rin,
  input  logic [CW-1:0] gin,
  input  logic [CW-1:0] bin,
  sprite_overlay_if.master rom,
  output logic [CW-1:0] rout,
  output logic [CW-1:0] gout,
  output logic [CW-1:0] bout,
  output logic          hit
);

  localparam int NPIX = SPR_W * SPR_H;
  localparam int AW   = $clog2(NPIX);
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPR_H);

  // Position: pending registers take writes; active registers drive the window.
  logic [9:0] act_x, act_y, pend_x, pend_y;
  logic       busy;
  logic [9:0] cap_x, cap_y;

  assign cap_x    = (pos_x > X_MAX) ? X_MAX : pos_x;
  assign cap_y    = (pos_y > Y_MAX) ? Y_MAX : pos_y;
  assign pos_busy = busy;

  // Apply uses the pending value from before this edge, so a simultaneous
  // write is kept pending for the next frame rather than applied immediately.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      act_x  <= '0;
      act_y  <= '0;
      pend_x <= '0;
      pend_y <= '0;
      busy   <= 1'b0;
    end else begin
      if (frame_start && busy) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
      if (pos_wr) begin
        pend_x <= cap_x;
        pend_y <= cap_y;
        busy   <= 1'b1;
      end else if (frame_start) begin
        busy <= 1'b0;
      end
    end
  end

  logic visible;

`ifdef SPRITE_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`else
  assign visible = 1'b1;
`endif

  // Stage 0: window test with 11-bit end coordinates so right/bottom edges
  // near 1023 cannot wrap.
  logic [10:0] x_end, y_end;
  logic        in_win;

  assign x_end  = {1'b0, act_x} + 11'(SPR_W);
  assign y_end  = {1'b0, act_y} + 11'(SPR_H);
  assign in_win = visible && pixelEN &&
                  (hcount >= act_x) && ({1'b0, hcount} < x_end) &&
                  (vcount >= act_y) && ({1'b0, vcount} < y_end);

  logic [AW-1:0] addr_cnt;

  always_ff @(posedge vgaclk) begin
    if (reset || frame_start) begin
      addr_cnt <= '0;
    end else if (in_win) begin
      addr_cnt <= (addr_cnt == AW'(NPIX - 1)) ? '0 : addr_cnt + AW'(1);
    end
  end

  assign rom.rom_addr = addr_cnt;

  logic          en_d, win_d;
  logic [CW-1:0] rin_d, gin_d, bin_d;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      en_d  <= 1'b0;
      win_d <= 1'b0;
      rin_d <= '0;
      gin_d <= '0;
      bin_d <= '0;
    end else begin
      en_d  <= pixelEN;
      win_d <= in_win;
      rin_d <= rin;
      gin_d <= gin;
      bin_d <= bin;
    end
  end

  // Stage 1: ROM word for the stage-0 address is now on rom_data.
  logic          key;
  logic [CW-1:0] img_r, img_g, img_b;
  logic [CW-1:0] nxt_r, nxt_g, nxt_b;
  logic          nxt_hit;

  assign key   = rom.rom_data[3*CW];
  assign img_r = rom.rom_data[3*CW-1 -: CW];
  assign img_g = rom.rom_data[2*CW-1 -: CW];
  assign img_b = rom.rom_data[CW-1 -: CW];

  always_comb begin
    nxt_r   = rin_d;
    nxt_g   = gin_d;
    nxt_b   = bin_d;
    nxt_hit = 1'b0;
    if (win_d) begin
      case (mode)
        2'b01: begin
          nxt_r   = rin_d ^ ~img_r;
          nxt_g   = gin_d ^ ~img_g;
          nxt_b   = bin_d ^ ~img_b;
          nxt_hit = 1'b1;
        end
        2'b10: begin
          nxt_r   = img_r;
          nxt_g   = img_g;
          nxt_b   = img_b;
          nxt_hit = 1'b1;
        end
        2'b11: begin
          if (!key) begin
            nxt_r   = img_r;
            nxt_g   = img_g;
            nxt_b   = img_b;
            nxt_hit = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (!en_d) begin
      nxt_r   = '0;
      nxt_g   = '0;
      nxt_b   = '0;
      nxt_hit = 1'b0;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      rout <= '0;
      gout <= '0;
      bout <= '0;
      hit  <= 1'b0;
    end else begin
      rout <= nxt_r;
      gout <= nxt_g;
      bout <= nxt_b;
      hit  <= nxt_hit;
    end
  end

endmodule

// File: tb/tb_sprite_overlay.sv
// tb_sprite_overlay: directed stimulus for sprite_overlay with a frame-level
// model (position registers, window count, ROM contents, blend table) checked
// against the DUT every cycle, plus literal expectations for key pixels.
module tb_sprite_overlay;

  localparam int SPR_W = 30;
  localparam int SPR_H = 30;
  localparam int NPIX  = SPR_W * SPR_H;
  localparam int BF    = 2;
  localparam int NREC  = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixelEN = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic       frame_start = 1'b0;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic       pos_wr = 1'b0;
  logic       pos_busy;
  logic [1:0] mode = 2'b00;
  logic       rin = 1'b0, gin = 1'b0, bin = 1'b0;
  logic       rout, gout, bout, hit;
  int         rom_sel = 0;
  logic [3:0] rom_q;

  sprite_overlay_if #(.AW(10), .DW(4)) rif ();

  sprite_overlay #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .CW(1),
    .H_ACTIVE(640), .V_ACTIVE(480), .BLINK_FRAMES(BF)
  ) dut (
    .vgaclk(clk), .reset(reset), .pixelEN(pixelEN),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .pos_wr(pos_wr), .pos_busy(pos_busy),
    .mode(mode), .rin(rin), .gin(gin), .bin(bin),
    .rom(rif),
    .rout(rout), .gout(gout), .bout(bout), .hit(hit)
  );

  always #5 clk = ~clk;

  // ROM contents: 0 all-zero, 1 patterned, 2 keyed black, 3 opaque black.
  function automatic logic [3:0] rom_word(input int sel, input int a);
    logic [9:0] av;
    av = 10'(a);
    case (sel)
      0:       return 4'b0000;
      1:       return {((a % 5) == 2), av[2:0]};
      2:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) rom_q <= rom_word(rom_sel, int'(rif.rom_addr));
  assign rif.rom_data = rom_q;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model state and per-cycle records
  int  m_ax, m_ay, m_px, m_py, m_cnt, m_fcnt;
  bit  m_busy, m_vis;
  int  cyc = 0;
  bit  run = 1'b0;

  bit        rec_en  [NREC];
  bit        rec_win [NREC];
  bit [2:0]  rec_in  [NREC];
  bit [2:0]  rec_img [NREC];
  bit        rec_key [NREC];
  bit [1:0]  rec_mode[NREC];
  int        rec_addr[NREC];
  bit        rec_busy[NREC];

  logic [2:0] obs_rgb [NREC];
  logic       obs_hit [NREC];
  logic [9:0] obs_addr[NREC];
  logic       obs_busy[NREC];

  // Consumes the inputs currently applied, advances the model, then waits
  // for the next falling edge where the caller sets the next inputs.
  task automatic tick();
    int k, h, v;
    bit w;
    logic [3:0] rw;
    k = cyc;
    h = int'(hcount);
    v = int'(vcount);
    w = !reset && pixelEN && m_vis &&
        h >= m_ax && h < m_ax + SPR_W && v >= m_ay && v < m_ay + SPR_H;
    rw = rom_word(rom_sel, m_cnt);
    rec_en[k]   = !reset && pixelEN;
    rec_win[k]  = w;
    rec_in[k]   = {rin, gin, bin};
    rec_img[k]  = rw[2:0];
    rec_key[k]  = rw[3];
    rec_mode[k] = mode;
    rec_addr[k] = m_cnt;
    if (reset) begin
      m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
      m_busy = 0; m_cnt = 0; m_vis = 1; m_fcnt = 0;
    end else begin
      if (frame_start && m_busy) begin
        m_ax = m_px; m_ay = m_py; m_busy = 0;
      end
      if (pos_wr) begin
        m_px = (int'(pos_x) > 640 - SPR_W) ? 640 - SPR_W : int'(pos_x);
        m_py = (int'(pos_y) > 480 - SPR_H) ? 480 - SPR_H : int'(pos_y);
        m_busy = 1;
      end
      if (frame_start) m_cnt = 0;
      else if (w) m_cnt = (m_cnt + 1) % NPIX;
`ifdef SPRITE_BLINK_EN
      if (frame_start) begin
        m_fcnt++;
        if (m_fcnt == BF) begin m_fcnt = 0; m_vis = !m_vis; end
      end
`endif
    end
    rec_busy[k] = m_busy;
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  // Every-cycle compare: output of pixel k-2, address of pixel k, busy after k-1.
  initial begin
    int k, j;
    logic [2:0] e_rgb;
    logic       e_hit;
    forever begin
      @(negedge clk);
      #2;
      if (run && cyc >= 3) begin
        k = cyc - 1;
        j = k - 2;
        e_rgb = 3'b000;
        e_hit = 1'b0;
        if (rec_en[j]) begin
          e_rgb = rec_in[j];
          if (rec_win[j]) begin
            case (rec_mode[j+1])
              2'd1: begin e_rgb = rec_in[j] ^ ~rec_img[j]; e_hit = 1; end
              2'd2: begin e_rgb = rec_img[j]; e_hit = 1; end
              2'd3: if (!rec_key[j]) begin e_rgb = rec_img[j]; e_hit = 1; end
              default: ;
            endcase
          end
        end
        chk("pix_rgb", {rout, gout, bout}, e_rgb);
        chk("pix_hit", hit, e_hit);
        chk("rom_addr", rif.rom_addr, rec_addr[k]);
        chk("pos_busy", pos_busy, rec_busy[k-1]);
        obs_rgb[j]    = {rout, gout, bout};
        obs_hit[j]    = hit;
        obs_addr[k]   = rif.rom_addr;
        obs_busy[k-1] = pos_busy;
      end
    end
  end

  task automatic pix(input bit en, input int h, input int v, input logic [2:0] rgb, output int idx);
    reset = 0; frame_start = 0; pos_wr = 0;
    pixelEN = en; hcount = 10'(h); vcount = 10'(v);
    {rin, gin, bin} = rgb;
    idx = cyc;
    tick();
  endtask

  task automatic ctl(input bit fs, input bit wr, input int x, input int y, output int idx);
    reset = 0; pixelEN = 0; frame_start = fs; pos_wr = wr;
    pos_x = 10'(x); pos_y = 10'(y);
    idx = cyc;
    tick();
    frame_start = 0; pos_wr = 0;
  endtask

  task automatic idle(input int n);
    int d;
    for (int i = 0; i < n; i++) pix(0, 0, 0, 3'b000, d);
  endtask

  task automatic do_reset();
    idle(1);
    reset = 1; pixelEN = 0; frame_start = 0; pos_wr = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, a0, a30, av30, b_wr, b_pre, b_fs, b_first, b_last, b_after;
    int c0, c1, c2, c3, d_fs, d1, d2, d_fs2, d3, d4, e1, e2, e3, e4;
    int bl[5];
    @(negedge clk);
    run = 1;
    reset = 1;
    tick();
    tick();
    reset = 0;
    idle(2);
    chk("reset_rgb", {rout, gout, bout}, 3'b000);
    chk("reset_hit", hit, 1'b0);
    chk("reset_busy", pos_busy, 1'b0);
    chk("reset_addr", rif.rom_addr, 10'd0);

    // A: invert over all-zero image at (0,0)
    do_reset();
    mode = 2'b01; rom_sel = 0;
    ctl(1, 0, 0, 0, d);
    for (int h = 0; h < 32; h++) begin
      pix(1, h, 0, 3'b111, d);
      if (h == 0) a0 = d;
      if (h == 30) a30 = d;
    end
    pix(1, 0, 30, 3'b111, av30);
    idle(3);
    chk("A_p00_rgb", obs_rgb[a0], 3'b000);
    chk("A_p00_hit", obs_hit[a0], 1'b1);
    chk("A_p30_rgb", obs_rgb[a30], 3'b111);
    chk("A_p30_hit", obs_hit[a30], 1'b0);
    chk("A_row30_hit", obs_hit[av30], 1'b0);

    // B: move to (100,50) mid-frame, full window scan next frame
    do_reset();
    mode = 2'b10; rom_sel = 1;
    ctl(0, 1, 100, 50, b_wr);
    pix(1, 100, 50, 3'b111, b_pre);
    ctl(1, 0, 0, 0, b_fs);
    for (int v = 50; v < 80; v++) begin
      for (int h = 99; h < 131; h++) begin
        if (v == 60 && h == 110) mode = 2'b11;
        if (v == 62 && h == 99) mode = 2'b10;
        pix(1, h, v, 3'b010, d);
        if (v == 50 && h == 100) b_first = d;
        if (v == 79 && h == 129) b_last = d;
        if (v == 79 && h == 130) b_after = d;
      end
    end
    idle(3);
    chk("B_busy_wr", obs_busy[b_wr], 1'b1);
    chk("B_busy_prefs", obs_busy[b_fs-1], 1'b1);
    chk("B_busy_fs", obs_busy[b_fs], 1'b0);
    chk("B_old_pos_hit", obs_hit[b_pre], 1'b0);
    chk("B_first_addr", obs_addr[b_first], 10'd0);
    chk("B_first_hit", obs_hit[b_first], 1'b1);
    chk("B_last_addr", obs_addr[b_last], 10'd899);
    chk("B_wrap_addr", obs_addr[b_after], 10'd0);

    // C: clamping of (700,470) to (610,450)
    do_reset();
    mode = 2'b10; rom_sel = 3;
    ctl(0, 1, 700, 470, d);
    ctl(1, 0, 0, 0, d);
    pix(1, 609, 450, 3'b111, c0);
    pix(1, 610, 450, 3'b111, c1);
    pix(1, 639, 479, 3'b111, c2);
    pix(1, 639, 449, 3'b111, c3);
    idle(3);
    chk("C_609_hit", obs_hit[c0], 1'b0);
    chk("C_610_hit", obs_hit[c1], 1'b1);
    chk("C_639_479_hit", obs_hit[c2], 1'b1);
    chk("C_639_479_rgb", obs_rgb[c2], 3'b000);
    chk("C_639_449_hit", obs_hit[c3], 1'b0);

    // D: write coinciding with frame_start
    do_reset();
    mode = 2'b10; rom_sel = 3;
    ctl(0, 1, 10, 10, d);
    ctl(1, 1, 20, 20, d_fs);
    pix(1, 10, 10, 3'b111, d1);
    pix(1, 9, 10, 3'b111, d2);
    ctl(1, 0, 0, 0, d_fs2);
    pix(1, 10, 10, 3'b111, d3);
    pix(1, 49, 49, 3'b111, d4);
    idle(3);
    chk("D_busy_samecyc", obs_busy[d_fs], 1'b1);
    chk("D_p10_hit", obs_hit[d1], 1'b1);
    chk("D_p9_hit", obs_hit[d2], 1'b0);
    chk("D_busy_fs2", obs_busy[d_fs2], 1'b0);
    chk("D_p10_after_hit", obs_hit[d3], 1'b0);
`ifdef SPRITE_BLINK_EN
    chk("D_p49_hit", obs_hit[d4], 1'b0);
`else
    chk("D_p49_hit", obs_hit[d4], 1'b1);
`endif

    // E: colour key, blanking and mode off
    do_reset();
    mode = 2'b11; rom_sel = 2;
    pix(1, 5, 5, 3'b101, e1);
    rom_sel = 3;
    pix(1, 6, 5, 3'b101, e2);
    pix(0, 7, 5, 3'b101, e3);
    pix(1, 8, 5, 3'b101, d);
    mode = 2'b00;
    pix(1, 9, 5, 3'b101, e4);
    idle(3);
    chk("E_key1_rgb", obs_rgb[e1], 3'b101);
    chk("E_key1_hit", obs_hit[e1], 1'b0);
    chk("E_key0_rgb", obs_rgb[e2], 3'b000);
    chk("E_key0_hit", obs_hit[e2], 1'b1);
    chk("E_blank_rgb", obs_rgb[e3], 3'b000);
    chk("E_off_rgb", obs_rgb[e4], 3'b101);
    chk("E_off_hit", obs_hit[e4], 1'b0);

`ifdef SPRITE_BLINK_EN
    // Blink: frames 0-1 visible, 2-3 hidden, 4 visible
    do_reset();
    mode = 2'b10; rom_sel = 3;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) ctl(1, 0, 0, 0, d);
      pix(1, 0, 0, 3'b111, bl[f]);
    end
    idle(3);
    chk("BL_f0_hit", obs_hit[bl[0]], 1'b1);
    chk("BL_f1_hit", obs_hit[bl[1]], 1'b1);
    chk("BL_f2_hit", obs_hit[bl[2]], 1'b0);
    chk("BL_f2_rgb", obs_rgb[bl[2]], 3'b111);
    chk("BL_f3_hit", obs_hit[bl[3]], 1'b0);
    chk("BL_f4_hit", obs_hit[bl[4]], 1'b1);
`endif

    idle(2);
    run = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sprite_overlay.md
# sprite_overlay

Parametrised sprite overlay for the VGA pixel pipeline: draws a SPR_W×SPR_H bitmap from an external synchronous ROM at a programmable screen position, in one of four blend modes, over the incoming RGB stream. Sits between the background/tile generator and the VGA output register. Replaces fixed-size, invert-only overlays. Adds position updates that take effect only between frames, edge clamping and a registered two-stage pixel path.

## Interface
Parameters:
- SPR_W, 30, sprite width in pixels
- SPR_H, 30, sprite height in pixels
- CW, 1, bits per colour channel
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BLINK_FRAMES, 32, frames per blink phase (only with SPRITE_BLINK_EN)

Ports:
- vgaclk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- pixelEN  in  1  active-video qualifier for the current pixel
- hcount  in  10  current pixel column
- vcount  in  10  current line
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pos_x  in  10  requested sprite left column
- pos_y  in  10  requested sprite top line
- pos_wr  in  1  capture pos_x/pos_y as the pending position
- pos_busy  out  1  pending position not yet applied
- mode  in  2  00 off, 01 invert, 10 replace, 11 colour-keyed replace
- rin, gin, bin  in  CW each  background colour
- rom_addr  out  clog2(SPR_W*SPR_H)  sprite ROM address; ROM data is valid 1 cycle later
- rom_data  in  3*CW+1  {key, r, g, b}
- rout, gout, bout  out  CW each  registered output colour
- hit  out  1  registered; the output pixel is an opaque sprite pixel

## Operation
- Reset: all outputs 0, active position (0,0), pending cleared, address counter 0, blink phase visible.
- Position capture: pos_wr loads the pending registers and sets pos_busy. pos_x is clamped to H_ACTIVE−SPR_W and pos_y to V_ACTIVE−SPR_H on capture. A later pos_wr while busy overwrites the pending value (last write wins).
- Position apply: on frame_start with pos_busy=1, the pending value becomes active and pos_busy clears. If pos_wr and frame_start occur in the same cycle, the old pending value (if any) is applied, the new value is captured, and pos_busy stays 1.
- Window: in_win = pixelEN && pos_x ≤ hcount < pos_x+SPR_W && pos_y ≤ vcount < pos_y+SPR_H. All comparisons use the active position, with 11-bit unsigned sums.
- Address: counter resets to 0 on frame_start and increments on each in_win cycle, in row-major order. It wraps from SPR_W*SPR_H−1 to 0. rom_addr is the counter value.
- Blend, per channel, with img = rom_data bits:
  - mode 00: out = in.
  - mode 01: out = in XOR ~img.
  - mode 10: out = img.
  - mode 11: out = key ? in : img.
- Outside the window, out = in.
- Blanking: if the delayed pixelEN is 0, out = 0 and hit = 0.
- hit = windowed && mode≠00 && !(mode==11 && key) && visible.

## Timing
- Stage 0: in_win and rom_addr are computed. rin/gin/bin, pixelEN and in_win are registered.
- Stage 1: rom_data arrives and the blend is registered into rout/gout/bout/hit.
- Fixed latency: 2 vgaclk cycles from input pixel to output pixel. The sync path must be delayed by 2 cycles outside this block.
- mode is sampled in stage 1. A change mid-line takes effect on the next output pixel.
- Reset asserted mid-frame: the next cycle shows reset values. The address resumes from 0 and stays misaligned until the next frame_start. This is acceptable.

## Configuration
- SPRITE_BLINK_EN defined:
  - A frame counter counts frame_start pulses.
  - The visible flag toggles every BLINK_FRAMES frames.
  - While not visible, the window is treated as empty and the address counter does not advance.
  - Reset sets visible=1 and counter=0.
- Undefined: no counter logic; visible is constant 1.

## Test plan
- Reset, mode=01, pos (0,0), rom_data all-zero img: pixel (0,0) with rin=1 gives rout=0 two cycles later; pixel (30,0) gives rout=1; hit is 1 only inside the 30×30 window.
- pos_wr (100,50) mid-frame: active position is unchanged until frame_start. pos_busy is 1 until the cycle after frame_start. In the next frame, the first rom_addr=0 is at (100,50), and rom_addr=899 is at (129,79).
- pos_wr (700,470): clamped to (610,450). The sprite's last column is 639 and its last row is 479.
- pos_wr and frame_start in the same cycle, with pending (10,10) and new (20,20): (10,10) is applied, pos_busy stays 1, and (20,20) is applied on the following frame_start.
- mode=11, key=1 with img=000, over background 101: output is 101 and hit=0. With key=0, output is 000 and hit=1. With pixelEN=0, output is 000.
- With SPRITE_BLINK_EN and BLINK_FRAMES=2: the sprite is visible in frames 0–1, hidden in frames 2–3 (output = background, hit=0), and visible again in frame 4.
